// File: rtl/dff_pipe_if.sv
// dff_pipe_if: control, data-in and result bundle of the dff_pipe delay line.
// The master drives the enable/flush/data side; the slave (the pipe) drives
// the registered results and the occupancy count.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic             d_valid;
  logic [WIDTH-1:0] d;
  logic             q_valid;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic [CW-1:0]    count;
  logic             q_par_err;

  modport master (
    output en, flush, d_valid, d,
    input  q_valid, q, qbar, count, q_par_err
  );

  modport slave (
    input  en, flush, d_valid, d,
    output q_valid, q, qbar, count, q_par_err
  );
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage registered delay line with per-stage
// valid bits, clock-enable stall, synchronous flush, an occupancy counter
// and a complementary output.
// Optional: define DFF_PIPE_PARITY_EN to carry an even-parity bit with each
// stage and flag q_par_err when the last stage's data and parity disagree.

// One pipeline stage: data word (plus parity when enabled) and its valid bit.
module dff_pipe_stage #(
  parameter int           W   = 8,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         flush,
  input  logic         d_vld,
  input  logic [W-1:0] d,
  output logic         q_vld,
  output logic [W-1:0] q
);
  // reset > flush > enable; bubbles still move data, only the valid says so
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= RST;
      q_vld <= 1'b0;
    end else if (flush) begin
      q     <= RST;
      q_vld <= 1'b0;
    end else if (en) begin
      q     <= d;
      q_vld <= d_vld;
    end
  end
endmodule

module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic         clk,
  input logic         rst_n,
  dff_pipe_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);

`ifdef DFF_PIPE_PARITY_EN
  localparam int                PW      = 1;
  localparam logic [WIDTH:0]    STG_RST = {^RESET_VAL, RESET_VAL};
`else
  localparam int                PW      = 0;
  localparam logic [WIDTH-1:0]  STG_RST = RESET_VAL;
`endif
  localparam int SW = WIDTH + PW;

  logic [DEPTH-1:0][SW-1:0] stg_d;
  logic [DEPTH-1:0][SW-1:0] stg_q;
  logic [DEPTH-1:0]         vld_d;
  logic [DEPTH-1:0]         vld_pipe;
  logic [SW-1:0]            cap;
  logic [CW-1:0]            cnt;

  // stage-0 capture word; parity is computed once here and then just travels
`ifdef DFF_PIPE_PARITY_EN
  assign cap = {^bus.d, bus.d};
`else
  assign cap = bus.d;
`endif

  // shift wiring: stage 0 takes the input, stage i takes stage i-1
  always_comb begin
    stg_d    = '0;
    vld_d    = '0;
    stg_d[0] = cap;
    vld_d[0] = bus.d_valid;
    for (int i = 1; i < DEPTH; i++) begin
      stg_d[i] = stg_q[i-1];
      vld_d[i] = vld_pipe[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stg
    dff_pipe_stage #(.W(SW), .RST(STG_RST)) u_stg (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.en),
      .flush (bus.flush),
      .d_vld (vld_d[g]),
      .d     (stg_d[g]),
      .q_vld (vld_pipe[g]),
      .q     (stg_q[g])
    );
  end

  // occupancy: +1 for a valid word entering, -1 for a valid word leaving;
  // both only on enabled edges, so the result stays within 0..DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cnt <= '0;
    else if (bus.flush) cnt <= '0;
    else if (bus.en)    cnt <= cnt + CW'(bus.d_valid) - CW'(vld_pipe[DEPTH-1]);
  end

  assign bus.q       = stg_q[DEPTH-1][WIDTH-1:0];
  assign bus.qbar    = ~stg_q[DEPTH-1][WIDTH-1:0];
  assign bus.q_valid = vld_pipe[DEPTH-1];
  assign bus.count   = cnt;

`ifdef DFF_PIPE_PARITY_EN
  assign bus.q_par_err = vld_pipe[DEPTH-1] &
                         ((^stg_q[DEPTH-1][WIDTH-1:0]) != stg_q[DEPTH-1][WIDTH]);
`else
  assign bus.q_par_err = 1'b0;
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed vector table plus hand sequences for async reset,
// release and (when built with DFF_PIPE_PARITY_EN) parity corruption.
module tb_dff_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       flush;
    logic       dv;
    logic [7:0] d;
    logic       qv;
    logic [7:0] q;
    logic [2:0] cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic en, input logic fl, input logic dv,
                     input logic [7:0] d, input logic qv, input logic [7:0] q,
                     input logic [2:0] cnt);
    vec_t v;
    v.en = en; v.flush = fl; v.dv = dv; v.d = d;
    v.qv = qv; v.q = q; v.cnt = cnt;
    vt.push_back(v);
  endtask

  task automatic drive(input logic en, input logic fl, input logic dv, input logic [7:0] d);
    bus.en = en; bus.flush = fl; bus.d_valid = dv; bus.d = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic qv, input logic [7:0] q,
                       input logic [2:0] cnt, input logic err);
    total++;
    if (bus.q_valid !== qv) begin
      bad++;
      $display("FAIL %s q_valid got=%0b exp=%0b", nm, bus.q_valid, qv);
    end
    total++;
    if (bus.q !== q) begin
      bad++;
      $display("FAIL %s q got=%02h exp=%02h", nm, bus.q, q);
    end
    total++;
    if (bus.qbar !== ~q) begin
      bad++;
      $display("FAIL %s qbar got=%02h exp=%02h", nm, bus.qbar, ~q);
    end
    total++;
    if (bus.count !== cnt) begin
      bad++;
      $display("FAIL %s count got=%0d exp=%0d", nm, bus.count, cnt);
    end
    total++;
    if (bus.q_par_err !== err) begin
      bad++;
      $display("FAIL %s q_par_err got=%0b exp=%0b", nm, bus.q_par_err, err);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // single pulse with an unqualified bubble carrying 0x77 behind it
    add(1,0,1,8'hA5, 0,8'h00,3'd1);
    add(1,0,0,8'h77, 0,8'h00,3'd1);
    add(1,0,0,8'h00, 0,8'h00,3'd1);
    add(1,0,0,8'h00, 1,8'hA5,3'd1);
    add(1,0,0,8'h00, 0,8'h77,3'd0);
    // continuous stream 01..08, then drain
    add(1,0,1,8'h01, 0,8'h00,3'd1);
    add(1,0,1,8'h02, 0,8'h00,3'd2);
    add(1,0,1,8'h03, 0,8'h00,3'd3);
    add(1,0,1,8'h04, 1,8'h01,3'd4);
    add(1,0,1,8'h05, 1,8'h02,3'd4);
    add(1,0,1,8'h06, 1,8'h03,3'd4);
    add(1,0,1,8'h07, 1,8'h04,3'd4);
    add(1,0,1,8'h08, 1,8'h05,3'd4);
    add(1,0,0,8'h00, 1,8'h06,3'd3);
    add(1,0,0,8'h00, 1,8'h07,3'd2);
    add(1,0,0,8'h00, 1,8'h08,3'd1);
    add(1,0,0,8'h00, 0,8'h00,3'd0);
    // count=3 then flush with en=0 and a valid 0xEE that must vanish
    add(1,0,1,8'hC1, 0,8'h00,3'd1);
    add(1,0,1,8'hC2, 0,8'h00,3'd2);
    add(1,0,1,8'hC3, 0,8'h00,3'd3);
    add(0,1,1,8'hEE, 0,8'h00,3'd0);
    add(1,0,0,8'h00, 0,8'h00,3'd0);
    add(1,0,0,8'h00, 0,8'h00,3'd0);
    add(1,0,0,8'h00, 0,8'h00,3'd0);
    add(1,0,0,8'h00, 0,8'h00,3'd0);
    // stall: push 11,22, hold 3 cycles, resume; then stall while q is valid
    add(1,0,1,8'h11, 0,8'h00,3'd1);
    add(1,0,1,8'h22, 0,8'h00,3'd2);
    add(0,0,1,8'h99, 0,8'h00,3'd2);
    add(0,0,1,8'h99, 0,8'h00,3'd2);
    add(0,0,1,8'h99, 0,8'h00,3'd2);
    add(1,0,0,8'h00, 0,8'h00,3'd2);
    add(1,0,0,8'h00, 1,8'h11,3'd2);
    add(0,0,1,8'h99, 1,8'h11,3'd2);
    add(1,0,0,8'h00, 1,8'h22,3'd1);
    add(1,0,0,8'h00, 0,8'h00,3'd0);

    // reset state while held in reset
    #12;
    check("reset_hold", 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].flush, vt[i].dv, vt[i].d);
      tick();
      check($sformatf("vec%0d", i), vt[i].qv, vt[i].q, vt[i].cnt, 1'b0);
    end

    // async reset mid-stream: 11,22,33,44 fill the pipe, q=11 valid
    drive(1'b1, 1'b0, 1'b1, 8'h11); tick();
    drive(1'b1, 1'b0, 1'b1, 8'h22); tick();
    drive(1'b1, 1'b0, 1'b1, 8'h33); tick();
    drive(1'b1, 1'b0, 1'b1, 8'h44); tick();
    check("prefill", 1'b1, 8'h11, 3'd4, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 1'b0, 8'h00, 3'd0, 1'b0);
    tick();
    check("rst_edge", 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    check("rst_release", 1'b0, 8'h00, 3'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post_rst%0d", k), 1'b0, 8'h00, 3'd0, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b1, 8'h3C); tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00); tick(); tick(); tick();
    check("post_rst_new", 1'b1, 8'h3C, 3'd1, 1'b0);
    tick();
    check("post_rst_drain", 1'b0, 8'h00, 3'd0, 1'b0);

    // 0x5A with clean parity: no error while it sits in the last stage
    drive(1'b1, 1'b0, 1'b1, 8'h5A); tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00); tick(); tick(); tick();
    check("par_clean", 1'b1, 8'h5A, 3'd1, 1'b0);
    tick();
    check("par_clean_out", 1'b0, 8'h00, 3'd0, 1'b0);

`ifdef DFF_PIPE_PARITY_EN
    // same stream, then flip q[0] of the last stage while it is valid
    drive(1'b1, 1'b0, 1'b1, 8'h5A); tick();
    drive(1'b1, 1'b0, 1'b0, 8'h00); tick(); tick(); tick();
    force dut.g_stg[3].u_stg.q = 9'h05B;
    #1;
    check("par_force", 1'b1, 8'h5B, 3'd1, 1'b1);
    release dut.g_stg[3].u_stg.q;
    tick();
    check("par_after", 1'b0, 8'h00, 3'd0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
